// File: rtl/ct_f_spsram_4096x84_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_4096x84_ctrl
// Access controller for a single-port SRAM macro (2^ADDR_WIDTH x DATA_WIDTH).
// After reset it optionally zero-fills every entry, then shares the single
// port between two requesters with round-robin arbitration.
//
// Ports:
//   CLK, RST            clock shared with the macro; synchronous active-high reset
//   reqN_vld/wr/addr    requester N access request (N = 0, 1); wr=1 is a write
//   reqN_wdata/wmask    write data and active-high per-bit write enable
//   reqN_gnt            request N accepted this cycle (combinational)
//   rsp_vld/rsp_id      read response valid (registered) and issuing requester
//   rsp_data            read data, passed straight through from Q
//   init_done           zero-fill complete; requests are being arbitrated
//   A/CEN/GWEN/WEN/D    macro address, active-low enables and write data
//   Q                   macro read data
// ---------------------------------------------------------------------------
module ct_f_spsram_4096x84_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 84,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_gnt,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_gnt,
  output logic                  rsp_vld,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  // rr_q names the requester that wins the next contended cycle.
  logic                    rr_q, rr_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic                    rsp_id_q, rsp_id_d;
  logic                    init_done_q, init_done_d;

  logic                    gnt0, gnt1, pick1;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata, sel_wmask;
  logic [ADDR_WIDTH-1:0]   a_s;
  logic                    cen_s, gwen_s;
  logic [DATA_WIDTH-1:0]   wen_s, d_s;

  // Requester 1 wins if it alone is valid, or both are valid and it holds priority.
  always_comb begin
    pick1     = req1_vld & (~req0_vld | rr_q);
    sel_wr    = pick1 ? req1_wr    : req0_wr;
    sel_addr  = pick1 ? req1_addr  : req0_addr;
    sel_wdata = pick1 ? req1_wdata : req0_wdata;
    sel_wmask = pick1 ? req1_wmask : req0_wmask;
  end

  // Next-state, grant and macro pin generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    rsp_vld_d   = 1'b0;
    rsp_id_d    = rsp_id_q;
    init_done_d = init_done_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    a_s         = ADDR_ZERO;
    cen_s       = 1'b1;
    gwen_s      = 1'b1;
    wen_s       = DATA_ONES;
    d_s         = DATA_ZERO;

    if (RST) begin
      // Pins stay idle while reset is held; the sweep restarts from address 0.
      state_d     = INIT_EN ? ST_INIT : ST_RUN;
      cnt_d       = ADDR_ZERO;
      rr_d        = 1'b0;
      init_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          a_s    = cnt_q;
          cen_s  = 1'b0;
          gwen_s = 1'b0;
          wen_s  = DATA_ZERO;
          d_s    = DATA_ZERO;
          cnt_d  = cnt_q + ADDR_ONE;
          if (cnt_q == ADDR_LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            state_d     = ST_INIT;
          end
        end
        ST_RUN: begin
          init_done_d = 1'b1;
          // init_done_q gates arbitration so grants never precede init_done.
          if (init_done_q && (req0_vld || req1_vld)) begin
            gnt0   = ~pick1;
            gnt1   = pick1;
            rr_d   = ~pick1;
            a_s    = sel_addr;
            cen_s  = 1'b0;
            if (sel_wr) begin
              gwen_s = 1'b0;
              wen_s  = ~sel_wmask;
              d_s    = sel_wdata;
            end else begin
              rsp_vld_d = 1'b1;
              rsp_id_d  = pick1;
            end
          end else begin
            rr_d = rr_q;
          end
        end
        default: begin
          state_d     = ST_INIT;
          cnt_d       = ADDR_ZERO;
          init_done_d = 1'b0;
        end
      endcase
    end
  end

  // State, counter, arbitration pointer and response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q       <= ADDR_ZERO;
      rr_q        <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_id_q    <= rsp_id_d;
      init_done_q <= init_done_d;
    end
  end

  assign req0_gnt  = gnt0;
  assign req1_gnt  = gnt1;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = Q;
  assign init_done = init_done_q;
  assign A         = a_s;
  assign CEN       = cen_s;
  assign GWEN      = gwen_s;
  assign WEN       = wen_s;
  assign D         = d_s;

endmodule

// File: tb/tb_ct_f_spsram_4096x84_ctrl.sv
// Self-checking bench: a behavioural SRAM sits on the macro pins, a reference
// memory predicts read data, and a scoreboard queue matches responses.
module tb_ct_f_spsram_4096x84_ctrl;
  localparam int AW    = 12;
  localparam int DW    = 84;
  localparam int DEPTH = 4096;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0_vld, req0_wr, req1_vld, req1_wr;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
  logic          req0_gnt, req1_gnt, rsp_vld, rsp_id, init_done;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] A;
  logic          CEN, GWEN;
  logic [DW-1:0] WEN, D, Q;

  ct_f_spsram_4096x84_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_gnt(req0_gnt),
    .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_gnt(req1_gnt),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .init_done(init_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port macro: registered read, bit-masked write.
  logic [DW-1:0] sram [0:DEPTH-1];
  logic [DW-1:0] q_r;
  assign Q = q_r;
  always @(posedge CLK) begin
    if (CEN === 1'b0) begin
      if (GWEN === 1'b0) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else               q_r     <= sram[A];
    end
  end

  // Reference model state.
  typedef struct { logic id; logic [DW-1:0] data; } rsp_t;
  rsp_t          exp_q[$];
  rsp_t          mon_e;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic          last_gnt;   // requester granted most recently
  logic          run_exp;    // model believes arbitration is active
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Response monitor: every rsp_vld must match the oldest expected read.
  always @(negedge CLK) begin
    if (rsp_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", DW'(1), DW'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", DW'(rsp_id), DW'(mon_e.id));
        chk("rsp_data", rsp_data, mon_e.data);
      end
    end
  end

  task automatic idle_inputs();
    req0_vld = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_vld = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
  endtask

  // Hold RST for n cycles (called at a negedge); checks the pins stay idle.
  task automatic do_reset(input int n);
    RST = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rst_cen", DW'(CEN), DW'(1));
      chk("rst_gwen", DW'(GWEN), DW'(1));
      chk("rst_wen", WEN, {DW{1'b1}});
      chk("rst_gnt", DW'({req0_gnt, req1_gnt}), DW'(0));
      if (k > 0) begin
        chk("rst_rsp_vld", DW'(rsp_vld), DW'(0));
        chk("rst_init_done", DW'(init_done), DW'(0));
      end
      @(negedge CLK);
    end
    RST      = 1'b0;
    run_exp  = 1'b0;
    last_gnt = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Watch n sweep cycles: every cycle must be a zero write to the next address.
  task automatic sweep(input int n);
    int err = 0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== '0 || D !== '0 ||
          A !== AW'(k) || req0_gnt !== 1'b0 || req1_gnt !== 1'b0 || init_done !== 1'b0)
        err++;
      @(negedge CLK);
    end
    chk("init_sweep_errs", DW'(err), DW'(0));
  endtask

  // One cycle of requests, checked against the round-robin rules.
  task automatic issue(input logic v0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [DW-1:0] m1);
    logic          g_any, g;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d, m;
    rsp_t          e;
    req0_vld = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0; req0_wmask = m0;
    req1_vld = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1; req1_wmask = m1;
    #1;
    g_any = run_exp && (v0 || v1);
    if (v0 && v1) g = ~last_gnt;
    else          g = v1;
    chk("init_done", DW'(init_done), DW'(run_exp));
    chk("gnt0", DW'(req0_gnt), DW'(g_any && !g));
    chk("gnt1", DW'(req1_gnt), DW'(g_any && g));
    if (g_any) begin
      w = g ? w1 : w0; a = g ? a1 : a0; d = g ? d1 : d0; m = g ? m1 : m0;
      chk("cen_gnt", DW'(CEN), DW'(0));
      chk("addr", DW'(A), DW'(a));
      chk("gwen", DW'(GWEN), DW'(!w));
      if (w) begin
        chk("wen", WEN, ~m);
        chk("wdata", D, d);
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      end else begin
        chk("wen_rd", WEN, {DW{1'b1}});
        e.id = g; e.data = ref_mem[a];
        exp_q.push_back(e);
      end
      last_gnt = g;
    end else begin
      chk("cen_idle", DW'(CEN), DW'(1));
    end
    @(negedge CLK);
  endtask

  logic [DW-1:0] ones, fmask, rd0, rd1, rm0, rm1;

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = rnd();
  end

  initial begin
    ones  = {DW{1'b1}};
    fmask = {{(DW-4){1'b1}}, 4'h0};
    idle_inputs();
    RST = 1'b1;
    // Requester 0 waits through init with a read of the last address.
    req0_vld = 1'b1; req0_addr = 12'hFFF;
    @(negedge CLK);
    do_reset(3);
    sweep(DEPTH);
    run_exp = 1'b1;
    issue(1'b1, 1'b0, 12'hFFF, '0, '0, 1'b0, 1'b0, '0, '0, '0);

    // Write then read-after-write from the other requester.
    issue(1'b1, 1'b1, 12'h123, ones, ones, 1'b0, 1'b0, '0, '0, '0);
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h123, '0, '0);

    // Contention: six back-to-back reads alternate between requesters.
    for (int k = 0; k < 6; k++)
      issue(1'b1, 1'b0, 12'h123, '0, '0, 1'b1, 1'b0, AW'(k), '0, '0);

    // Masked write into a zeroed location, then read it back.
    issue(1'b1, 1'b1, 12'h200, ones, fmask, 1'b0, 1'b0, '0, '0, '0);
    issue(1'b1, 1'b0, 12'h200, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    // All-zero mask occupies the port but changes nothing.
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 12'h200, '0, '0);
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h200, '0, '0);

    // Random traffic over a small address window to exercise hazards.
    for (int k = 0; k < 400; k++) begin
      rd0 = rnd(); rd1 = rnd();
      rm0 = ($urandom_range(0, 7) == 0) ? '0 : rnd();
      rm1 = ($urandom_range(0, 7) == 0) ? '0 : rnd();
      issue(1'($urandom), 1'($urandom), AW'(12'h120 + $urandom_range(0, 7)), rd0, rm0,
            1'($urandom), 1'($urandom), AW'(12'h120 + $urandom_range(0, 7)), rd1, rm1);
    end
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    chk("queue_drained_run", DW'(exp_q.size()), DW'(0));

    // Reset in RUN with a read pending: no grant, no response afterwards.
    req0_vld = 1'b1; req0_addr = 12'h123;
    do_reset(2);
    idle_inputs();
    // Reset again part-way through the sweep: it must restart from 0.
    sweep(100);
    do_reset(1);
    sweep(DEPTH);
    run_exp = 1'b1;
    issue(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h123, '0, '0);
    issue(1'b1, 1'b0, 12'h200, '0, '0, 1'b1, 1'b0, 12'hFFF, '0, '0);
    issue(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    issue(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("queue_drained_end", DW'(exp_q.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
